fx_mac_ci: RTL

- Parametrised fixed-point multiply/multiply-accumulate unit with a Nios II multi-cycle custom-instruction interface (start/done, n opcode field).
- Successor to the fixed single-function mul_add instruction: adds configurable width, Q-format, multiplier pipeline depth, an internal accumulator and saturation.
- Serves the CORDIC post-scaling path (gain compensation, dot products).

---
 rtl/fx_mac_ci.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fx_mac_ci.sv
// Fixed-point multiply / multiply-accumulate unit with a multi-cycle custom-instruction handshake.
// Optional build macro ROUND_EN: round the product half toward +inf before the Q-format shift.
module fx_mac_ci #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 22,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             clk_en,
    input  logic             start,
    input  logic [1:0]       n,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MAC  = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;
    localparam int         PW      = 2 * WIDTH + 1;
    localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);
`ifdef ROUND_EN
    localparam logic [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
`endif

    state_t                 state_r, state_nx_s;
    logic [2:0]             cnt_r, cnt_nx_s;
    logic                   accept_s, fin_s;
    logic [1:0]             op_r;
    logic [WIDTH-1:0]       a_r, b_r, acc_r, result_r;
    logic                   done_r;
    logic [2*WIDTH-1:0]     mult_s;
    logic [2*WIDTH-1:0]     pipe_r [LATENCY];
    logic [PW-1:0]          wide_s;
    logic signed [PW-1:0]   scaled_s;
    logic [WIDTH-1:0]       psat_s, mac_s, add_s, res_s, acc_nx_s;

    // Clamp a wide signed value into the WIDTH-bit two's complement range.
    function automatic logic [WIDTH-1:0] sat_f(input logic [PW-1:0] v);
        if (v[PW-1:WIDTH-1] == {(PW-WIDTH+1){v[PW-1]}}) begin
            return v[WIDTH-1:0];
        end else if (v[PW-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    function automatic logic [PW-1:0] sext_f(input logic [WIDTH-1:0] x);
        return {{(PW-WIDTH){x[WIDTH-1]}}, x};
    endfunction

    // Next-state logic; a start is refused while the previous done pulse is still visible.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        fin_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !done_r) begin
                    accept_s   = 1'b1;
                    cnt_nx_s   = 3'd0;
                    state_nx_s = (n == OP_MUL || n == OP_MAC) ? S_MULT : S_FIN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_MULT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = S_FIN;
                end else begin
                    cnt_nx_s = cnt_r + 3'd1;
                end
            end
            S_FIN: begin
                fin_s      = 1'b1;
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State and counter registers, frozen while clk_en is low.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_r <= S_IDLE;
            cnt_r   <= 3'd0;
        end else if (clk_en) begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Operand capture on an accepted start.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            op_r <= 2'd0;
            a_r  <= '0;
            b_r  <= '0;
        end else if (clk_en && accept_s) begin
            op_r <= n;
            a_r  <= dataa;
            b_r  <= datab;
        end
    end

    // Operands are sign-extended so the truncated 2*WIDTH product is the exact signed product.
    assign mult_s = {{WIDTH{a_r[WIDTH-1]}}, a_r} * {{WIDTH{b_r[WIDTH-1]}}, b_r};

    // Free-running multiplier pipeline; its last stage is valid once MULT has counted out.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < LATENCY; i++) pipe_r[i] <= '0;
        end else if (clk_en) begin
            pipe_r[0] <= mult_s;
            for (int i = 1; i < LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    // Q-format scaling, saturation and per-opcode result/accumulator selection.
    always_comb begin
        wide_s = {pipe_r[LATENCY-1][2*WIDTH-1], pipe_r[LATENCY-1]};
`ifdef ROUND_EN
        wide_s = wide_s + RND;
`endif
        scaled_s = $signed(wide_s) >>> FRAC;
        psat_s   = sat_f(scaled_s);
        mac_s    = sat_f(sext_f(acc_r) + sext_f(psat_s));
        add_s    = sat_f(sext_f(a_r) + sext_f(b_r));
        res_s    = psat_s;
        acc_nx_s = acc_r;
        case (op_r)
            OP_MUL:  begin res_s = psat_s; acc_nx_s = acc_r; end
            OP_MAC:  begin res_s = mac_s;  acc_nx_s = mac_s; end
            OP_ADD:  begin res_s = add_s;  acc_nx_s = acc_r; end
            OP_LOAD: begin res_s = acc_r;  acc_nx_s = a_r;   end
            default: begin res_s = psat_s; acc_nx_s = acc_r; end
        endcase
    end

    // Output and accumulator registers; done and result hold while clk_en is low.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            done_r   <= 1'b0;
            result_r <= '0;
            acc_r    <= '0;
        end else if (clk_en) begin
            done_r <= fin_s;
            if (fin_s) begin
                result_r <= res_s;
                acc_r    <= acc_nx_s;
            end
        end
    end

    assign result = result_r;
    assign done   = done_r;

endmodule
